// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline control for the 5-stage F/D/E/M/W processor. This block has three
// parts:
//   * E-stage operand forwarding selects (ForwardAE / ForwardBE).
//   * Load-use, PC-write and taken-branch hazard detection, which drives the
//     stall and flush strobes for the pipeline registers.
//   * A small sequencer that holds E for the full duration of a multi-cycle
//     multiply.
//
// All strobes are combinational from the inputs and the sequencer state. The
// only registered state is the sequencer state and its down-counter.
//
// Ports
//   clk, reset_n          clock (rising edge); asynchronous active-low reset
//   RA1D, RA2D            source registers of the instruction in D
//   RA1E, RA2E            source registers of the instruction in E
//   WA3E, WA3M, WA3W      destination registers in E / M / W
//   RegWriteE/M/W         instruction in E / M / W writes the register file
//   MemtoRegE             instruction in E is a load
//   PCSrcD/E/M/W          instruction in D / E / M / W writes the PC
//   BranchTakenE          branch in E is taken (already condition-gated)
//   MulStartE, CondExE    instruction in E is a multiply; its condition passed
//   ForwardAE, ForwardBE  00 regfile, 01 result from W, 10 ALU result from M
//   StallF/D/E            hold PC, F/D register, D/E register
//   FlushD/E/M            bubble into F/D, D/E, E/M register
//   MulBusy               multiply sequencer is in BUSY (its full state)
//   MulDoneE              multiply result is valid in E this cycle
//
// There is no valid/ready handshake here: every strobe is a level that applies
// to the current cycle only.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int REG_AW      = 4,
    // Total E-stage cycles of a multiply, issue cycle included. Legal 2..16.
    parameter int MUL_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA1E,
    input  logic [REG_AW-1:0] RA2E,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [REG_AW-1:0] WA3M,
    input  logic [REG_AW-1:0] WA3W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              PCSrcD,
    input  logic              PCSrcE,
    input  logic              PCSrcM,
    input  logic              PCSrcW,
    input  logic              BranchTakenE,
    input  logic              MulStartE,
    input  logic              CondExE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MulBusy,
    output logic              MulDoneE
);

    // R15 is the PC; it is never forwarded from the pipeline.
    localparam logic [REG_AW-1:0] PC_REG   = REG_AW'(15);
    // The issue cycle and the done cycle are not counted by cnt, hence -2.
    localparam logic [3:0]        CNT_INIT = 4'(MUL_LATENCY - 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

    mul_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic mulstall_raw;
    logic mul_done_raw;
    logic mulstall;
    logic ldstall;
    logic pcpend;

    // ------------------------------------------------------------------
    // Forwarding: M has priority over W because it holds the younger value.
    // ------------------------------------------------------------------
    always_comb begin
        ForwardAE = 2'b00;
        if (RA1E != PC_REG) begin
            if (RegWriteM && (WA3M == RA1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (WA3W == RA1E)) begin
                ForwardAE = 2'b01;
            end
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RA2E != PC_REG) begin
            if (RegWriteM && (WA3M == RA2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (WA3W == RA2E)) begin
                ForwardBE = 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign ldstall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    assign pcpend  = PCSrcD | PCSrcE | PCSrcM;

    // ------------------------------------------------------------------
    // Multiply sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Multiply sequencer: next state and strobes
    // The issue cycle stalls combinationally from IDLE so the op is held in E
    // from its very first cycle. MulStartE is ignored while BUSY because the
    // multiply itself is still the instruction sitting in E.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mulstall_raw = 1'b0;
        mul_done_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulStartE && CondExE) begin
                    mulstall_raw = 1'b1;
                    cnt_d        = CNT_INIT;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    mulstall_raw = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                end else begin
                    mul_done_raw = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // While reset is held the issue path must not stall, even if MulStartE is
    // still asserted, so an aborted op releases the pipeline in the same cycle.
    assign mulstall = mulstall_raw & reset_n;
    assign MulDoneE = mul_done_raw & reset_n;
    assign MulBusy  = (state_q == BUSY);

    // ------------------------------------------------------------------
    // Stall / flush strobes. A stalled register is never also flushed.
    // ------------------------------------------------------------------
    assign StallF = ldstall | pcpend | mulstall;
    assign StallD = ldstall | mulstall;
    assign StallE = mulstall;
    assign FlushM = mulstall;
    assign FlushE = (ldstall | BranchTakenE) & ~mulstall;
    assign FlushD = (pcpend | PCSrcW | BranchTakenE) & ~StallD;

endmodule
